// File: rtl/ttt_game_controller.sv
// ttt_game_controller: human-vs-bot N-in-a-row controller; the bot scans one line per cycle
// for a win candidate, then a block candidate, and falls back to the centre or lowest free cell.
module ttt_game_controller #(
  parameter int N = 3,
  parameter bit BOT_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       start,
  input  logic                       mv_valid,
  input  logic [$clog2(N*N)-1:0]     mv_idx,
  output logic                       mv_ready,
  output logic [N*N-1:0]             red_board,
  output logic [N*N-1:0]             grn_board,
  output logic                       bot_valid,
  output logic [$clog2(N*N)-1:0]     bot_idx,
  output logic                       illegal,
  output logic                       r_win,
  output logic                       g_win,
  output logic                       draw,
  output logic                       busy
);
  localparam int C = N * N;
  localparam int L = 2 * N + 2;
  localparam int IW = $clog2(C);
  localparam int LW = $clog2(L);
  localparam int CTR = (C - 1) / 2;
  typedef enum logic [2:0] {IDLE, WAIT_HUMAN, CHECK_H, SCAN, PLACE, CHECK_G, DONE} state_t;
  state_t state_q;
  logic [C-1:0] red_q, grn_q, empty, cur_m, ln_e;
  logic [IW-1:0] bot_idx_q, win_i_q, blk_i_q, pick_d, ln_i;
  logic [LW-1:0] line_q;
  logic bot_valid_q, illegal_q, r_win_q, g_win_q, draw_q, win_v_q, blk_v_q;
  logic g_cand, r_cand, r_line, g_line, full;
  // Lines 0..N-1 are rows, N..2N-1 columns, then main and anti diagonal.
  function automatic logic [C-1:0] line_mask(input int k);
    for (int i = 0; i < C; i++)
      line_mask[i] = k < N ? i / N == k : k < 2 * N ? i % N == k - N :
                     k == 2 * N ? i / N == i % N : i / N + i % N == N - 1;
  endfunction
  function automatic logic [IW-1:0] low_idx(input logic [C-1:0] v);
    low_idx = '0;
    for (int i = C - 1; i >= 0; i--) if (v[i]) low_idx = IW'(i);
  endfunction
  function automatic logic any_line(input logic [C-1:0] b);
    any_line = 1'b0;
    for (int k = 0; k < L; k++) if ((b & line_mask(k)) == line_mask(k)) any_line = 1'b1;
  endfunction
  always_comb begin
    empty = ~(red_q | grn_q);
    full = &(red_q | grn_q);
    cur_m = line_mask(int'(line_q));
    ln_e = cur_m & empty;
    ln_i = low_idx(ln_e);
    g_cand = $countones(ln_e) == 1 && $countones(cur_m & grn_q) == N - 1;
    r_cand = $countones(ln_e) == 1 && $countones(cur_m & red_q) == N - 1;
    r_line = any_line(red_q);
    g_line = any_line(grn_q);
    pick_d = win_v_q ? win_i_q : blk_v_q ? blk_i_q :
             (N % 2 == 1 && empty[CTR]) ? IW'(CTR) : low_idx(empty);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      red_q <= '0;
      grn_q <= '0;
      bot_idx_q <= '0;
      win_i_q <= '0;
      blk_i_q <= '0;
      line_q <= '0;
      bot_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      r_win_q <= 1'b0;
      g_win_q <= 1'b0;
      draw_q <= 1'b0;
      win_v_q <= 1'b0;
      blk_v_q <= 1'b0;
    end else begin
      bot_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      if (start) begin
        state_q <= BOT_FIRST ? SCAN : WAIT_HUMAN;
        red_q <= '0;
        grn_q <= '0;
        bot_idx_q <= '0;
        r_win_q <= 1'b0;
        g_win_q <= 1'b0;
        draw_q <= 1'b0;
        line_q <= '0;
        win_v_q <= 1'b0;
        blk_v_q <= 1'b0;
      end else begin
        case (state_q)
          WAIT_HUMAN: if (mv_valid) begin
            if (int'(mv_idx) >= C || !empty[mv_idx]) illegal_q <= 1'b1;
            else begin
              red_q[mv_idx] <= 1'b1;
              state_q <= CHECK_H;
            end
          end
          CHECK_H: begin
            r_win_q <= r_line;
            draw_q <= !r_line && full;
            state_q <= (r_line || full) ? DONE : SCAN;
            line_q <= '0;
            win_v_q <= 1'b0;
            blk_v_q <= 1'b0;
          end
          SCAN: begin
            if (g_cand && !win_v_q) begin
              win_v_q <= 1'b1;
              win_i_q <= ln_i;
            end
            if (r_cand && !blk_v_q) begin
              blk_v_q <= 1'b1;
              blk_i_q <= ln_i;
            end
            line_q <= line_q + 1'b1;
            if (line_q == LW'(L - 1)) state_q <= PLACE;
          end
          PLACE: begin
            grn_q[pick_d] <= 1'b1;
            bot_idx_q <= pick_d;
            bot_valid_q <= 1'b1;
            state_q <= CHECK_G;
          end
          CHECK_G: begin
            g_win_q <= g_line;
            draw_q <= !g_line && full;
            state_q <= (g_line || full) ? DONE : WAIT_HUMAN;
          end
          default: ;
        endcase
      end
    end
  end
  assign mv_ready = state_q == WAIT_HUMAN;
  assign busy = !(state_q inside {IDLE, WAIT_HUMAN, DONE});
  assign red_board = red_q;
  assign grn_board = grn_q;
  assign bot_valid = bot_valid_q;
  assign bot_idx = bot_idx_q;
  assign illegal = illegal_q;
  assign r_win = r_win_q;
  assign g_win = g_win_q;
  assign draw = draw_q;
endmodule

// File: tb/tb_ttt_game_controller.sv
// tb_ttt_game_controller: directed and random games against a board-array reference model.
module tb_ttt_game_controller;
  logic clk = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;
  logic s3 = 0, v3 = 0, rdy3, bv3, il3, rw3, gw3, dr3, by3;
  logic [3:0] i3 = 0, bi3;
  logic [8:0] rb3, gb3;
  logic s4 = 0, v4 = 0, rdy4, bv4, il4, rw4, gw4, dr4, by4;
  logic [3:0] i4 = 0, bi4;
  logic [15:0] rb4, gb4;
  logic sb = 0, vb = 0, rdyb, bvb, ilb, rwb, gwb, drb, byb;
  logic [3:0] ib = 0, bib;
  logic [8:0] rbb, gbb;
  ttt_game_controller #(.N(3), .BOT_FIRST(1'b0)) d3 (.clk(clk), .clr(clr), .start(s3), .mv_valid(v3),
    .mv_idx(i3), .mv_ready(rdy3), .red_board(rb3), .grn_board(gb3), .bot_valid(bv3), .bot_idx(bi3),
    .illegal(il3), .r_win(rw3), .g_win(gw3), .draw(dr3), .busy(by3));
  ttt_game_controller #(.N(4), .BOT_FIRST(1'b0)) d4 (.clk(clk), .clr(clr), .start(s4), .mv_valid(v4),
    .mv_idx(i4), .mv_ready(rdy4), .red_board(rb4), .grn_board(gb4), .bot_valid(bv4), .bot_idx(bi4),
    .illegal(il4), .r_win(rw4), .g_win(gw4), .draw(dr4), .busy(by4));
  ttt_game_controller #(.N(3), .BOT_FIRST(1'b1)) db (.clk(clk), .clr(clr), .start(sb), .mv_valid(vb),
    .mv_idx(ib), .mv_ready(rdyb), .red_board(rbb), .grn_board(gbb), .bot_valid(bvb), .bot_idx(bib),
    .illegal(ilb), .r_win(rwb), .g_win(gwb), .draw(drb), .busy(byb));
  int checks = 0, failures = 0;
  int bd [9];
  bit over;
  int ln [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [8:0] mask(input int p);
    mask = '0;
    for (int i = 0; i < 9; i++) mask[i] = bd[i] == p;
  endfunction
  function automatic bit won(input int p);
    won = 0;
    for (int k = 0; k < 8; k++) if (bd[ln[k][0]] == p && bd[ln[k][1]] == p && bd[ln[k][2]] == p) won = 1;
  endfunction
  function automatic bit full();
    full = 1;
    for (int i = 0; i < 9; i++) if (bd[i] == 0) full = 0;
  endfunction
  function automatic int model_bot();
    int win = -1, blk = -1;
    for (int k = 0; k < 8; k++) begin
      int g = 0, r = 0, e = 0, ec = 0;
      for (int j = 0; j < 3; j++) begin
        if (bd[ln[k][j]] == 2) g++;
        else if (bd[ln[k][j]] == 1) r++;
        else begin e++; ec = ln[k][j]; end
      end
      if (g == 2 && e == 1 && win < 0) win = ec;
      if (r == 2 && e == 1 && blk < 0) blk = ec;
    end
    if (win >= 0) return win;
    if (blk >= 0) return blk;
    if (bd[4] == 0) return 4;
    for (int i = 0; i < 9; i++) if (bd[i] == 0) return i;
    return -1;
  endfunction
  task automatic new_game3();
    s3 = 1; tick(); s3 = 0;
    for (int i = 0; i < 9; i++) bd[i] = 0;
    over = 0;
    chk("start_rdy", rdy3, 1);
    chk("start_boards", {rb3, gb3, bi3}, 0);
    chk("start_flags", {rw3, gw3, dr3, by3}, 0);
  endtask
  task automatic human3(input int idx);
    bit bad;
    int n, b;
    bad = (idx >= 9) ? 1'b1 : (bd[idx] != 0);
    v3 = 1; i3 = 4'(idx); tick(); v3 = 0;
    if (bad) begin
      chk("illegal", il3, 1);
      chk("illegal_red", rb3, mask(1));
      chk("illegal_grn", gb3, mask(2));
      chk("illegal_rdy", rdy3, 1);
      tick();
      chk("illegal_pulse", il3, 0);
      return;
    end
    bd[idx] = 1;
    chk("red_set", rb3, mask(1));
    chk("legal_no_illegal", il3, 0);
    chk("busy_check_h", by3, 1);
    if (won(1) || full()) begin
      tick();
      chk("r_win", rw3, won(1));
      chk("draw_h", dr3, !won(1));
      chk("done_rdy_h", {rdy3, by3, gw3}, 0);
      over = 1;
      return;
    end
    n = 0;
    while (!bv3 && n < 30) begin tick(); n++; end
    chk("bot_latency", n, 10);
    b = model_bot();
    bd[b] = 2;
    chk("bot_idx", bi3, b);
    chk("grn_board", gb3, mask(2));
    tick();
    chk("bot_valid_pulse", bv3, 0);
    chk("g_win", gw3, won(2));
    chk("draw_g", dr3, !won(2) && full());
    over = won(2) || full();
    chk("rdy_after_bot", rdy3, !over);
  endtask
  initial begin
    int n;
    #1 clr = 1;
    #2;
    chk("reset_outputs", {rdy3, rb3, gb3, bv3, bi3, il3, rw3, gw3, dr3, by3}, 0);
    tick(); tick();
    clr = 0;
    tick(); tick();
    chk("idle_after_reset", {rdy3, by3}, 0);
    new_game3();
    human3(4);
    chk("first_bot_grn", gb3, 9'h001);
    new_game3();
    human3(0);
    chk("block_first", bi3, 4);
    human3(1);
    chk("block_second", bi3, 2);
    human3(8);
    chk("win_over_block", {bi3, gw3, rdy3}, {4'd6, 1'b1, 1'b0});
    v3 = 1; i3 = 3; tick(); v3 = 0;
    chk("done_ignore_mv", {il3, rb3}, {1'b0, 9'h103});
    new_game3();
    human3(4);
    human3(4);
    human3(9);
    chk("illegal_boards", {rb3, gb3}, {9'h010, 9'h001});
    new_game3();
    v3 = 1; i3 = 4; tick(); v3 = 0;
    tick(); tick(); tick();
    chk("busy_scan", by3, 1);
    clr = 1;
    #2;
    chk("clr_mid_scan", {rdy3, rb3, gb3, bv3, bi3, il3, rw3, gw3, dr3, by3}, 0);
    n = 0;
    for (int i = 0; i < 15; i++) begin tick(); n += int'(bv3); end
    clr = 0;
    for (int i = 0; i < 5; i++) begin tick(); n += int'(bv3); end
    chk("clr_no_bot_valid", n, 0);
    chk("clr_stays_idle", rdy3, 0);
    new_game3();
    v3 = 1; i3 = 2; tick(); v3 = 0;
    tick(); tick(); tick();
    s3 = 1; tick(); s3 = 0;
    chk("restart_mid_scan", {rdy3, rb3, gb3}, {1'b1, 18'h0});
    n = 0;
    for (int i = 0; i < 12; i++) begin tick(); n += int'(bv3); end
    chk("restart_no_bot", n, 0);
    for (int g = 0; g < 25; g++) begin
      new_game3();
      for (int m = 0; m < 40 && !over; m++) human3(int'($urandom_range(0, 10)));
      chk("random_game_over", over, 1);
    end
    s4 = 1; tick(); s4 = 0;
    v4 = 1; i4 = 0; tick(); v4 = 0;
    n = 0;
    while (!bv4 && n < 30) begin tick(); n++; end
    chk("n4_latency", n, 12);
    chk("n4_bot", {bi4, gb4, rb4}, {4'd1, 16'h0002, 16'h0001});
    sb = 1; tick(); sb = 0;
    n = 0;
    while (!bvb && n < 30) begin tick(); n++; end
    chk("bf_latency", n, 9);
    chk("bf_bot", {bib, gbb}, {4'd4, 9'h010});
    tick();
    chk("bf_wait_human", rdyb, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
